// File: rtl/xyz_change_reader.sv
// Samples the z/y/x flags, queues every change as {new value, change mask} in a
// first-word-fall-through FIFO, and keeps saturating rising-edge counters per flag.
module xyz_change_reader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_srst,
    input  logic                     i_z,
    input  logic                     i_y,
    input  logic                     i_x,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [5:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_rise_z,
    output logic [CNT_W-1:0]         o_rise_y,
    output logic [CNT_W-1:0]         o_rise_x
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]        r_prev;
    logic [5:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_rise_z;
    logic [CNT_W-1:0]  r_rise_y;
    logic [CNT_W-1:0]  r_rise_x;

    logic [2:0]        w_cur;
    logic [2:0]        w_mask;
    logic [2:0]        w_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_drop;
    logic [LW-1:0]     w_level_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != CNT_MAX)) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        w_cur     = {i_z, i_y, i_x};
        w_mask    = w_cur ^ r_prev;
        w_rise    = w_cur & ~r_prev;
        w_push    = |w_mask;
        w_pop     = (r_level != '0) && i_ready;
        w_full    = (r_level == FULL_LVL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push_ok = w_push && (!w_full || w_pop);
        w_drop    = w_push && w_full && !w_pop;
        unique case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_prev     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_rise_z   <= '0;
            r_rise_y   <= '0;
            r_rise_x   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_srst) begin
            r_prev     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_rise_z   <= '0;
            r_rise_y   <= '0;
            r_rise_x   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_prev <= w_cur;
            if (w_push_ok) begin
                r_mem[r_wptr] <= {w_cur, w_mask};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_nxt;
            if (w_drop) r_overflow <= 1'b1;
            r_rise_z <= sat_inc(r_rise_z, w_rise[2]);
            r_rise_y <= sat_inc(r_rise_y, w_rise[1]);
            r_rise_x <= sat_inc(r_rise_x, w_rise[0]);
        end
    end

    assign o_valid    = (r_level != '0);
    assign o_data     = r_mem[r_rptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_rise_z   = r_rise_z;
    assign o_rise_y   = r_rise_y;
    assign o_rise_x   = r_rise_x;

endmodule

// File: tb/tb_xyz_change_reader.sv
// Scoreboard bench: a queue-based model predicts events and counters; a negedge
// monitor checks every handshake and the status outputs.
module tb_xyz_change_reader;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       srst = 1'b0;
    logic       z = 1'b0, y = 1'b0, x = 1'b0;
    logic       ready = 1'b0;

    logic       valid;
    logic [5:0] data;
    logic [2:0] level;
    logic       ovf;
    logic [7:0] rz, ry, rx;

    logic       valid2;
    logic [5:0] data2;
    logic [2:0] level2;
    logic       ovf2;
    logic [1:0] rz2, ry2, rx2;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [2:0] m_prev;
    int         m_level;
    logic       m_ovf;
    int         m_r  [3];
    int         m_r2 [3];
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    xyz_change_reader #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_srst(srst),
        .i_z(z), .i_y(y), .i_x(x),
        .o_valid(valid), .i_ready(ready), .o_data(data), .o_level(level),
        .o_overflow(ovf), .o_rise_z(rz), .o_rise_y(ry), .o_rise_x(rx)
    );

    xyz_change_reader #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_arst_n(arst_n), .i_srst(srst),
        .i_z(z), .i_y(y), .i_x(x),
        .o_valid(valid2), .i_ready(ready), .o_data(data2), .o_level(level2),
        .o_overflow(ovf2), .o_rise_z(rz2), .o_rise_y(ry2), .o_rise_x(rx2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 3'b000;
        m_level = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            m_r[f]  = 0;
            m_r2[f] = 0;
        end
    endtask

    // Applies the rules to the inputs sampled at the edge that just happened.
    task automatic model_update();
        logic [2:0] cur, mask;
        bit pop;
        int lvl_before;
        if (srst) begin
            model_reset();
            return;
        end
        cur = {z, y, x};
        mask = cur ^ m_prev;
        lvl_before = m_level;
        pop = (lvl_before > 0) && ready;
        if (pop) m_level--;
        if (mask != 3'b000) begin
            if (lvl_before < DEPTH || pop) begin
                exp_q.push_back({cur, mask});
                m_level++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        for (int f = 0; f < 3; f++) begin
            if (cur[f] && !m_prev[f]) begin
                if (m_r[f] < 255) m_r[f]++;
                if (m_r2[f] < 3) m_r2[f]++;
            end
        end
        m_prev = cur;
    endtask

    task automatic step(input logic iz, input logic iy, input logic ix,
                        input logic ir, input logic is);
        z = iz; y = iy; x = ix; ready = ir; srst = is;
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            chk("valid", valid, m_level != 0);
            chk("level", level, m_level);
            chk("overflow", ovf, m_ovf);
            chk("rise_z", rz, m_r[2]);
            chk("rise_y", ry, m_r[1]);
            chk("rise_x", rx, m_r[0]);
            chk("rise_z_w2", rz2, m_r2[2]);
            chk("rise_y_w2", ry2, m_r2[1]);
            chk("rise_x_w2", rx2, m_r2[0]);
            if (valid && ready && !srst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {26'd0, data}, 32'hffff_ffff);
                end else begin
                    chk("event_data", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic yv;
        logic xv;
        logic zv;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", {rz, ry, rx}, 0);
        @(negedge clk);
        #1 arst_n = 1'b1;

        // Single x rise and fall
        for (int c = 1; c <= 4; c++) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("x_rise_valid", valid, 1);
        chk("x_rise_data", data, 6'b001_001);
        chk("x_rise_cnt", rx, 1);
        step(0, 0, 1, 1, 0);
        chk("x_one_cycle", valid, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("x_fall_data", data, 6'b000_001);
        chk("x_fall_cnt", rx, 1);
        step(0, 0, 0, 1, 0);

        // All three rise together
        step(0, 0, 0, 1, 1);
        step(1, 1, 1, 1, 0);
        chk("all_data", data, 6'b111_111);
        chk("all_level", level, 1);
        chk("all_cnt", {rz, ry, rx}, {8'd1, 8'd1, 8'd1});
        step(1, 1, 1, 1, 0);

        // Overflow with ready low, then drain
        step(0, 0, 0, 0, 1);
        yv = 1'b0;
        for (int t = 0; t < 4; t++) begin
            yv = ~yv;
            step(0, yv, 0, 0, 0);
        end
        chk("ovf_full_level", level, 4);
        chk("ovf_not_yet", ovf, 0);
        yv = ~yv;
        step(0, yv, 0, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_level", level, 4);
        for (int t = 0; t < 6; t++) step(0, yv, 0, 1, 0);
        chk("ovf_drained", level, 0);
        chk("ovf_sticky", ovf, 1);

        // Full FIFO with simultaneous pop and push
        step(0, 0, 0, 0, 1);
        xv = 1'b0;
        for (int t = 0; t < 4; t++) begin
            xv = ~xv;
            step(0, 0, xv, 0, 0);
        end
        xv = ~xv;
        step(0, 0, xv, 1, 0);
        chk("fullpp_level", level, 4);
        chk("fullpp_ovf", ovf, 0);
        for (int t = 0; t < 6; t++) step(0, 0, xv, 1, 0);

        // Saturation of the narrow counters
        step(0, 0, 0, 1, 1);
        zv = 1'b0;
        for (int t = 0; t < 10; t++) begin
            zv = ~zv;
            step(zv, 0, 0, 1, 0);
        end
        for (int t = 0; t < 3; t++) step(zv, 0, 0, 1, 0);
        chk("sat_rz2", rz2, 3);
        chk("sat_rz8", rz, 5);

        // Synchronous clear mid-stream
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("pre_srst_level", level, 3);
        chk("pre_srst_ry", ry, 2);
        step(0, 1, 0, 0, 1);
        chk("srst_level", level, 0);
        chk("srst_valid", valid, 0);
        chk("srst_ovf", ovf, 0);
        chk("srst_cnt", {rz, ry, rx}, 0);

        // Asynchronous reset mid-stream
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        #1 arst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", valid, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_cnt", {rz, ry, rx}, 0);
        @(negedge clk);
        #1 arst_n = 1'b1;

        // Randomized traffic
        zv = 0; yv = 0; xv = 0;
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(3) == 0) zv = ~zv;
            if ($urandom_range(3) == 0) yv = ~yv;
            if ($urandom_range(3) == 0) xv = ~xv;
            step(zv, yv, xv, $urandom_range(2) != 0, $urandom_range(199) == 0);
        end
        for (int t = 0; t < 8; t++) step(zv, yv, xv, 1, 0);
        chk("final_empty", level, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
